// File: rtl/periph_router.sv
// periph_router: routes the arbiter's single memory port to rom/uart/clint/avl,
// tracking one outstanding transaction and answering unmapped or hung accesses.
// Ports:
//   clock, reset (async, active-low)
//   memory_* : arbiter request in, response (rdata/ready/bus_error) out
//   <t>_*    : per-target request out (valid, instr, addr, wdata, wstrb),
//              per-target response in (rdata, ready)
module periph_router #(
  parameter logic [31:0] ROM_BASE   = 32'h0000_0000,
  parameter logic [31:0] ROM_TOP    = 32'h0001_0000,
  parameter logic [31:0] UART_BASE  = 32'h0010_0000,
  parameter logic [31:0] UART_TOP   = 32'h0010_0004,
  parameter logic [31:0] CLINT_BASE = 32'h0200_0000,
  parameter logic [31:0] CLINT_TOP  = 32'h0200_C000,
  parameter logic [31:0] AVL_BASE   = 32'h8000_0000,
  parameter logic [31:0] AVL_TOP    = 32'h9000_0000,
  parameter int unsigned TIMEOUT    = 1024
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        memory_valid,
  input  logic        memory_instr,
  input  logic [31:0] memory_addr,
  input  logic [31:0] memory_wdata,
  input  logic [3:0]  memory_wstrb,
  output logic [31:0] memory_rdata,
  output logic        memory_ready,
  output logic        bus_error,
  output logic        rom_valid,
  output logic        rom_instr,
  output logic [31:0] rom_addr,
  input  logic [31:0] rom_rdata,
  input  logic        rom_ready,
  output logic        uart_valid,
  output logic        uart_instr,
  output logic [31:0] uart_addr,
  output logic [31:0] uart_wdata,
  output logic [3:0]  uart_wstrb,
  input  logic [31:0] uart_rdata,
  input  logic        uart_ready,
  output logic        clint_valid,
  output logic        clint_instr,
  output logic [31:0] clint_addr,
  output logic [31:0] clint_wdata,
  output logic [3:0]  clint_wstrb,
  input  logic [31:0] clint_rdata,
  input  logic        clint_ready,
  output logic        avl_valid,
  output logic        avl_instr,
  output logic [31:0] avl_addr,
  output logic [31:0] avl_wdata,
  output logic [3:0]  avl_wstrb,
  input  logic [31:0] avl_rdata,
  input  logic        avl_ready
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_ERR
  } state_t;

  typedef enum logic [2:0] {
    SEL_NONE,
    SEL_ROM,
    SEL_UART,
    SEL_CLINT,
    SEL_AVL
  } sel_t;

  localparam logic [15:0] TMAX = 16'(TIMEOUT - 1);

  state_t      r_state;
  sel_t        r_sel;
  logic [15:0] r_cnt;

  logic [31:0] w_rom_off;
  logic [31:0] w_uart_off;
  logic [31:0] w_clint_off;
  logic [31:0] w_avl_off;
  sel_t        w_hit;
  logic        w_req;
  logic        w_busy;
  logic        w_tmo;
  logic        w_sel_ready;
  logic [31:0] w_sel_rdata;

  // Offset compare covers [BASE,TOP) with one unsigned test and
  // doubles as the target-relative address.
  assign w_rom_off   = memory_addr - ROM_BASE;
  assign w_uart_off  = memory_addr - UART_BASE;
  assign w_clint_off = memory_addr - CLINT_BASE;
  assign w_avl_off   = memory_addr - AVL_BASE;

  always_comb begin
    w_hit = SEL_NONE;
    if (w_avl_off < (AVL_TOP - AVL_BASE))
      w_hit = SEL_AVL;
    else if (w_clint_off < (CLINT_TOP - CLINT_BASE))
      w_hit = SEL_CLINT;
    else if (w_uart_off < (UART_TOP - UART_BASE))
      w_hit = SEL_UART;
    else if (w_rom_off < (ROM_TOP - ROM_BASE))
      w_hit = SEL_ROM;
  end

  always_comb begin
    w_sel_ready = 1'b0;
    w_sel_rdata = '0;
    unique case (r_sel)
      SEL_ROM:   begin w_sel_ready = rom_ready;   w_sel_rdata = rom_rdata;   end
      SEL_UART:  begin w_sel_ready = uart_ready;  w_sel_rdata = uart_rdata;  end
      SEL_CLINT: begin w_sel_ready = clint_ready; w_sel_rdata = clint_rdata; end
      SEL_AVL:   begin w_sel_ready = avl_ready;   w_sel_rdata = avl_rdata;   end
      default:   ;
    endcase
  end

  assign w_req  = (r_state == S_IDLE) && memory_valid;
  assign w_busy = (r_state == S_BUSY);
  assign w_tmo  = (r_cnt == TMAX);

  assign rom_valid   = w_req && (w_hit == SEL_ROM);
  assign uart_valid  = w_req && (w_hit == SEL_UART);
  assign clint_valid = w_req && (w_hit == SEL_CLINT);
  assign avl_valid   = w_req && (w_hit == SEL_AVL);

  assign rom_instr   = memory_instr;
  assign rom_addr    = w_rom_off;
  assign uart_instr  = memory_instr;
  assign uart_addr   = w_uart_off;
  assign uart_wdata  = memory_wdata;
  assign uart_wstrb  = memory_wstrb;
  assign clint_instr = memory_instr;
  assign clint_addr  = w_clint_off;
  assign clint_wdata = memory_wdata;
  assign clint_wstrb = memory_wstrb;
  assign avl_instr   = memory_instr;
  assign avl_addr    = w_avl_off;
  assign avl_wdata   = memory_wdata;
  assign avl_wstrb   = memory_wstrb;

  // A real answer beats a timeout landing in the same cycle.
  assign memory_ready = (w_busy && (w_sel_ready || w_tmo))
                     || (r_state == S_ERR);
  assign memory_rdata = (w_busy && w_sel_ready) ? w_sel_rdata : '0;
  assign bus_error    = (r_state == S_ERR)
                     || (w_busy && !w_sel_ready && w_tmo);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_sel   <= SEL_NONE;
      r_cnt   <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (memory_valid) begin
            r_cnt <= '0;
            if (w_hit == SEL_NONE) begin
              r_state <= S_ERR;
            end else begin
              r_state <= S_BUSY;
              r_sel   <= w_hit;
            end
          end
        end
        S_BUSY: begin
          if (w_sel_ready || w_tmo) begin
            r_state <= S_IDLE;
            r_sel   <= SEL_NONE;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        S_ERR: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
          r_sel   <= SEL_NONE;
        end
      endcase
    end
  end

endmodule
